patch_fetch_ctrl: RTL and testbench
===================================

PATCH_FETCH_CTRL -- requirements
Module: patch_fetch_ctrl

Interface
REQ-001 Parameter DIM_W, default 8: width of image dimension and coordinate buses.
REQ-002 Parameter CHUNK, default 8: columns per fetch chunk, equal to the 8 processor lanes enabled by p_en.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  begin a scan; sampled only in IDLE.
REQ-006 patch_size  input  3  patch edge (valid 3, 5, 7).
REQ-007 stride  input  3  window stride (valid 1..patch_size).
REQ-008 img_width  input  DIM_W  image columns.
REQ-009 img_height  input  DIM_W  image rows.
REQ-010 fetch_ack  input  1  memory side has loaded the requested chunk.
REQ-011 fetch_req  output  1  chunk request, held until acknowledged.
REQ-012 row_base  output  DIM_W  top input row of the current window row.
REQ-013 col_base  output  DIM_W  first column of the current chunk.
REQ-014 cycle_detect  output  1  one-cycle pulse per loaded chunk, drives the enable generator.
REQ-015 done  output  1  one-cycle pulse at scan completion or config rejection.
REQ-016 busy  output  1  high from scan acceptance until done.
REQ-017 cfg_err  output  1  one-cycle pulse, coincident with done, on rejected config.

Function
REQ-018 FSM states SHALL be IDLE, CHECK, REQ, PULSE, NEXT and FIN.
REQ-019 IDLE with start=1 at edge T SHALL latch patch_size, stride, img_width and img_height, and enter CHECK; busy=1 from T+1.
REQ-020 CHECK SHALL reject the config if patch_size is not 3, 5 or 7, stride=0, stride>patch_size, img_width<patch_size, or img_height<patch_size.
REQ-021 On rejection, done=1 and cfg_err=1 SHALL be asserted for exactly one cycle at T+2, busy=0 at T+2, and the FSM SHALL return to IDLE; fetch_req SHALL never assert.
REQ-022 On acceptance, CHECK SHALL clear row_base and col_base to 0 and enter REQ; fetch_req=1 from T+2.
REQ-023 In REQ, fetch_req, row_base and col_base SHALL stay stable until fetch_ack=1 is sampled; fetch_ack sampled while fetch_req=0 SHALL be ignored.
REQ-024 When fetch_ack is sampled at edge K, fetch_req SHALL be 0 and cycle_detect SHALL be 1 during K+1 only (state PULSE).
REQ-025 NEXT SHALL define the last chunk as col_base+CHUNK >= img_width, and the last row as row_base+stride+patch_size > img_height; comparisons SHALL be carried out at DIM_W+1 bits with no wrap.
REQ-026 If the current chunk is not the last chunk, col_base SHALL advance by CHUNK.
REQ-027 If the current chunk is the last chunk but not the last row, col_base SHALL clear to 0 and row_base SHALL advance by stride.
REQ-028 In either advance case, fetch_req SHALL reassert at K+2.
REQ-029 On the last chunk of the last row, the FSM SHALL enter FIN; done=1 at K+2 for one cycle, busy=0 at K+2, then IDLE.
REQ-030 start SHALL be ignored while busy=1, including the done cycle.
REQ-031 Window rows SHALL equal (img_height-patch_size)/stride+1, chunks per row SHALL equal ceil(img_width/CHUNK), and cycle_detect pulses SHALL equal their product; the block SHALL not use a divider.

Reset
REQ-032 rst=0 SHALL immediately force IDLE, with fetch_req, cycle_detect, done, busy, cfg_err, row_base and col_base all 0, regardless of state.
REQ-033 After rst releases mid-scan, no residual pulse SHALL appear, and the next start SHALL begin a fresh scan from row 0, column 0.

Verification
REQ-034 patch 3, stride 1, 16x5, ack one cycle after each req -> 6 cycle_detect pulses at (row,col) (0,0),(0,8),(1,0),(1,8),(2,0),(2,8); done 1 cycle after the last pulse.
REQ-035 patch 5, stride 2, width 20, height 9 -> rows 0,2,4 with cols 0,8,16; 9 pulses, then done.
REQ-036 patch 4 (or stride 0, or img_height 2 with patch 3) -> done=cfg_err=1 at T+2, no fetch_req, busy low at T+2.
REQ-037 fetch_ack held low 10 cycles -> fetch_req stays 1 with stable coordinates and no cycle_detect; ack -> pulse next cycle.
REQ-038 start pulsed during busy and on the done cycle -> ignored, pulse count unchanged.
REQ-039 rst=0 asserted while fetch_req=1 at row 2 -> all outputs 0 asynchronously; restart -> first request at (0,0).

Source files
------------

// File: rtl/patch_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : patch_fetch_ctrl
//  Purpose  : Walks a sliding-window scan over an image and issues one fetch
//             request per CHUNK-column slice of each window row. Every loaded
//             chunk produces a one-cycle cycle_detect pulse for the lane
//             enable generator.
//  Ports    : clk, rst (async, active-low)
//             start, patch_size, stride, img_width, img_height : scan config
//             fetch_ack                : memory has loaded the requested chunk
//             fetch_req                : chunk request, held until acknowledged
//             row_base, col_base       : top row / first column of the chunk
//             cycle_detect             : one pulse per loaded chunk
//             done, cfg_err            : completion / rejection pulses
//             busy                     : scan in progress
//  Revision : 1.0 - initial release
// ============================================================================
module patch_fetch_ctrl #(
  parameter int DIM_W = 8,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       patch_size,
  input  logic [2:0]       stride,
  input  logic [DIM_W-1:0] img_width,
  input  logic [DIM_W-1:0] img_height,
  input  logic             fetch_ack,
  output logic             fetch_req,
  output logic [DIM_W-1:0] row_base,
  output logic [DIM_W-1:0] col_base,
  output logic             cycle_detect,
  output logic             done,
  output logic             busy,
  output logic             cfg_err
);

  // IDLE  : waiting for start
  // CHECK : validating the latched configuration
  // REQ   : request outstanding, waiting for fetch_ack
  // PULSE : chunk loaded, cycle_detect high; advance decided at its end
  // NEXT  : first cycle of a re-issued request after an advance; it accepts
  //         fetch_ack exactly like REQ so back-to-back acks lose no cycle
  // FIN   : done cycle; start is still ignored here
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    REQ   = 3'd2,
    PULSE = 3'd3,
    NEXT  = 3'd4,
    FIN   = 3'd5
  } state_t;

  localparam logic [DIM_W:0]   CHUNK_EXT = (DIM_W+1)'(CHUNK);
  localparam logic [DIM_W-1:0] CHUNK_STEP = DIM_W'(CHUNK);

  state_t           state;
  logic [2:0]       cfg_patch;
  logic [2:0]       cfg_stride;
  logic [DIM_W-1:0] cfg_width;
  logic [DIM_W-1:0] cfg_height;

  // End-of-row / end-of-image tests are done one bit wider than the
  // coordinate buses so a chunk or window near the top of the range cannot
  // wrap and look like it still fits.
  logic [DIM_W:0] chunk_end;
  logic [DIM_W:0] next_row_end;
  logic           last_chunk;
  logic           last_row;
  logic           patch_ok;
  logic           cfg_ok;

  assign chunk_end    = {1'b0, col_base} + CHUNK_EXT;
  assign next_row_end = {1'b0, row_base} + (DIM_W+1)'(cfg_stride) + (DIM_W+1)'(cfg_patch);
  assign last_chunk   = chunk_end >= {1'b0, cfg_width};
  assign last_row     = next_row_end > {1'b0, cfg_height};

  assign patch_ok = (cfg_patch == 3'd3) || (cfg_patch == 3'd5) || (cfg_patch == 3'd7);
  assign cfg_ok   = patch_ok
                 && (cfg_stride != 3'd0)
                 && (cfg_stride <= cfg_patch)
                 && (cfg_width  >= DIM_W'(cfg_patch))
                 && (cfg_height >= DIM_W'(cfg_patch));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cfg_patch    <= '0;
      cfg_stride   <= '0;
      cfg_width    <= '0;
      cfg_height   <= '0;
      fetch_req    <= 1'b0;
      row_base     <= '0;
      col_base     <= '0;
      cycle_detect <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      // Pulse outputs default low; each state raises them for one cycle.
      cycle_detect <= 1'b0;
      done         <= 1'b0;
      cfg_err      <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            cfg_patch  <= patch_size;
            cfg_stride <= stride;
            cfg_width  <= img_width;
            cfg_height <= img_height;
            busy       <= 1'b1;
            state      <= CHECK;
          end
        end

        CHECK: begin
          if (!cfg_ok) begin
            done    <= 1'b1;
            cfg_err <= 1'b1;
            busy    <= 1'b0;
            state   <= FIN;
          end else begin
            row_base  <= '0;
            col_base  <= '0;
            fetch_req <= 1'b1;
            state     <= REQ;
          end
        end

        REQ, NEXT: begin
          if (fetch_ack) begin
            fetch_req    <= 1'b0;
            cycle_detect <= 1'b1;
            state        <= PULSE;
          end else begin
            state <= REQ;
          end
        end

        PULSE: begin
          if (!last_chunk) begin
            col_base  <= col_base + CHUNK_STEP;
            fetch_req <= 1'b1;
            state     <= NEXT;
          end else if (!last_row) begin
            // The next window row still fits, so row_base + stride
            // cannot overflow here.
            col_base  <= '0;
            row_base  <= row_base + DIM_W'(cfg_stride);
            fetch_req <= 1'b1;
            state     <= NEXT;
          end else begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= FIN;
          end
        end

        FIN: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_patch_fetch_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_patch_fetch_ctrl
//  Purpose  : Self-checking bench for patch_fetch_ctrl. A transaction-level
//             model (window coordinate list + request/pulse/done protocol)
//             predicts every output each cycle; directed scenarios add
//             literal expectations, then a randomized phase follows.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_patch_fetch_ctrl;

  localparam int DIM_W = 8;
  localparam int CHUNK = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [2:0]       patch_size = 3'd3;
  logic [2:0]       stride = 3'd1;
  logic [DIM_W-1:0] img_width = 8'd16;
  logic [DIM_W-1:0] img_height = 8'd5;
  logic             fetch_ack = 1'b0;
  logic             fetch_req;
  logic [DIM_W-1:0] row_base;
  logic [DIM_W-1:0] col_base;
  logic             cycle_detect;
  logic             done;
  logic             busy;
  logic             cfg_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  patch_fetch_ctrl #(.DIM_W(DIM_W), .CHUNK(CHUNK)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .patch_size   (patch_size),
    .stride       (stride),
    .img_width    (img_width),
    .img_height   (img_height),
    .fetch_ack    (fetch_ack),
    .fetch_req    (fetch_req),
    .row_base     (row_base),
    .col_base     (col_base),
    .cycle_detect (cycle_detect),
    .done         (done),
    .busy         (busy),
    .cfg_err      (cfg_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int r;
    int c;
  } coord_t;

  coord_t exp_q[$];   // windows still to be fetched, in scan order
  coord_t obs_q[$];   // coordinates seen on cycle_detect pulses

  bit m_busy, m_req, m_pulse, m_done, m_err, m_check;
  bit n_busy, n_req, n_pulse, n_done, n_err, n_check;
  int m_p, m_s, m_w, m_h;

  int cyc = 0;
  int last_pulse_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  bit saw_req = 0;
  bit saw_err = 0;
  int ack_mode = 1;   // 0 random, 1 ack in first request cycle, 2 hold low

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      chk("rst_fetch_req", fetch_req, 0);
      chk("rst_cycle_detect", cycle_detect, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cfg_err", cfg_err, 0);
      chk("rst_row_base", row_base, 0);
      chk("rst_col_base", col_base, 0);
      m_busy = 0; m_req = 0; m_pulse = 0; m_done = 0; m_err = 0; m_check = 0;
      exp_q.delete();
    end else begin
      chk("busy", busy, m_busy);
      chk("fetch_req", fetch_req, m_req);
      chk("cycle_detect", cycle_detect, m_pulse);
      chk("done", done, m_done);
      chk("cfg_err", cfg_err, m_err);
      if (m_req || m_pulse) begin
        chk("model_has_window", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          chk("row_base", row_base, exp_q[0].r);
          chk("col_base", col_base, exp_q[0].c);
        end
      end
      if (cycle_detect) begin
        obs_q.push_back('{int'(row_base), int'(col_base)});
        last_pulse_cyc = cyc;
      end
      if (fetch_req) saw_req = 1;
      if (cfg_err) saw_err = 1;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end

      // Predict the next cycle from the inputs the next edge will sample.
      n_pulse = m_req && fetch_ack;
      n_req   = m_req && !fetch_ack;
      n_done  = 0;
      n_err   = 0;
      n_check = 0;
      n_busy  = m_busy;
      if (m_pulse) begin
        if (exp_q.size() > 0) exp_q.delete(0);
        if (exp_q.size() > 0) n_req = 1;
        else begin
          n_done = 1;
          n_busy = 0;
        end
      end
      if (m_check) begin
        if (!(m_p == 3 || m_p == 5 || m_p == 7) || m_s == 0 || m_s > m_p ||
            m_w < m_p || m_h < m_p) begin
          n_done = 1;
          n_err  = 1;
          n_busy = 0;
        end else begin
          exp_q.delete();
          for (int r = 0; r + m_p <= m_h; r += m_s)
            for (int c = 0; c < m_w; c += CHUNK)
              exp_q.push_back('{r, c});
          n_req = 1;
        end
      end
      if (!m_busy && !m_done && start) begin
        m_p = int'(patch_size);
        m_s = int'(stride);
        m_w = int'(img_width);
        m_h = int'(img_height);
        n_busy  = 1;
        n_check = 1;
      end
      m_busy = n_busy; m_req = n_req; m_pulse = n_pulse;
      m_done = n_done; m_err = n_err; m_check = n_check;
    end
  end

  // ---------------- stimulus ----------------
  always @(posedge clk) begin
    #1;
    case (ack_mode)
      0:       fetch_ack = ($urandom_range(0, 2) == 0);
      1:       fetch_ack = fetch_req;
      default: fetch_ack = 1'b0;
    endcase
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_obs();
    obs_q.delete();
    saw_req = 0;
    saw_err = 0;
  endtask

  task automatic pulse_start(input int p, input int s, input int w, input int h);
    patch_size = 3'(p);
    stride     = 3'(s);
    img_width  = 8'(w);
    img_height = 8'(h);
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    int d0;
    n = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      tick(1);
      n++;
    end
    chk(name, done_cnt - d0, 1);
  endtask

  int ra[6] = '{0, 0, 1, 1, 2, 2};
  int ca[6] = '{0, 8, 0, 8, 0, 8};
  int rej[3][4] = '{'{4, 1, 16, 5}, '{3, 0, 16, 5}, '{3, 1, 16, 2}};
  int s_cyc;
  int n;
  int d0;

  initial begin
    // Reset
    tick(3);
    rst = 1'b1;
    tick(2);
    chk("idle_busy", busy, 0);
    chk("idle_fetch_req", fetch_req, 0);

    // 16x5, patch 3, stride 1
    ack_mode = 1;
    clear_obs();
    pulse_start(3, 1, 16, 5);
    wait_done(200, "scanA_done");
    chk("scanA_pulses", obs_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < obs_q.size()) begin
        chk("scanA_row", obs_q[i].r, ra[i]);
        chk("scanA_col", obs_q[i].c, ca[i]);
      end
    end
    chk("scanA_done_gap", done_cyc - last_pulse_cyc, 1);
    tick(2);

    // 20x9, patch 5, stride 2
    clear_obs();
    pulse_start(5, 2, 20, 9);
    wait_done(300, "scanB_done");
    chk("scanB_pulses", obs_q.size(), 9);
    for (int i = 0; i < 9; i++) begin
      if (i < obs_q.size()) begin
        chk("scanB_row", obs_q[i].r, (i / 3) * 2);
        chk("scanB_col", obs_q[i].c, (i % 3) * 8);
      end
    end
    tick(2);

    // Rejected configurations
    for (int k = 0; k < 3; k++) begin
      clear_obs();
      s_cyc = cyc;
      pulse_start(rej[k][0], rej[k][1], rej[k][2], rej[k][3]);
      wait_done(20, "rej_done");
      chk("rej_cfg_err", saw_err, 1);
      chk("rej_no_req", saw_req, 0);
      chk("rej_latency", done_cyc - s_cyc, 3);
      chk("rej_pulses", obs_q.size(), 0);
      tick(2);
    end

    // Acknowledge withheld for 10 cycles
    ack_mode = 2;
    clear_obs();
    pulse_start(3, 1, 16, 3);
    n = 0;
    while (!fetch_req && n < 10) begin tick(1); n++; end
    tick(10);
    chk("hold_req", fetch_req, 1);
    chk("hold_row", row_base, 0);
    chk("hold_col", col_base, 0);
    chk("hold_no_pulse", obs_q.size(), 0);
    ack_mode = 1;
    wait_done(100, "hold_done");
    chk("hold_pulses", obs_q.size(), 2);
    tick(2);

    // start toggled while busy and held on the done cycle
    clear_obs();
    pulse_start(3, 1, 16, 5);
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < 200) begin
      start = done ? 1'b1 : 1'(($urandom_range(0, 1)));
      tick(1);
      n++;
    end
    start = 1'b0;
    chk("ignore_done", done_cnt - d0, 1);
    tick(3);
    chk("ignore_pulses", obs_q.size(), 6);
    chk("ignore_idle", busy, 0);

    // Asynchronous reset while requesting row 2
    clear_obs();
    pulse_start(3, 1, 16, 5);
    n = 0;
    while (!(fetch_req && row_base == 8'd2) && n < 100) begin tick(1); n++; end
    chk("rst_reach_row2", fetch_req && row_base == 8'd2, 1);
    rst = 1'b0;
    #1;
    chk("async_fetch_req", fetch_req, 0);
    chk("async_busy", busy, 0);
    chk("async_row", row_base, 0);
    chk("async_col", col_base, 0);
    chk("async_cd", cycle_detect, 0);
    tick(2);
    rst = 1'b1;
    tick(2);
    clear_obs();
    pulse_start(3, 1, 16, 5);
    wait_done(200, "restart_done");
    chk("restart_pulses", obs_q.size(), 6);
    if (obs_q.size() > 0) begin
      chk("restart_row0", obs_q[0].r, 0);
      chk("restart_col0", obs_q[0].c, 0);
    end

    // Randomized phase
    ack_mode = 0;
    for (int i = 0; i < 15000; i++) begin
      case ($urandom_range(0, 4))
        0: patch_size = 3'd3;
        1: patch_size = 3'd5;
        2: patch_size = 3'd7;
        3: patch_size = 3'($urandom_range(0, 7));
        default: patch_size = 3'd5;
      endcase
      stride     = 3'($urandom_range(0, 7));
      img_width  = 8'($urandom_range(1, 40));
      img_height = 8'($urandom_range(1, 20));
      start      = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2999) == 0) begin
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
      end
      tick(1);
    end
    start = 1'b0;
    n = 0;
    while (busy && n < 3000) begin tick(1); n++; end
    chk("final_idle", busy, 0);
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
